// File: rtl/regbank_pkg.sv
// Shared defaults and packed-slice helpers for the multi-port register bank.
// The IP occupies the top register index.
package regbank_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_REGS   = 16;
  localparam int DEF_IP_STEP    = 2;

  function automatic int ip_index(input int num_regs);
    return num_regs - 1;
  endfunction

  // Bit offset of port 'port' inside a packed address bus.
  function automatic int addr_lsb(input int port, input int aw);
    return port * aw;
  endfunction

  // Bit offset of port 'port' inside a packed data bus.
  function automatic int data_lsb(input int port, input int dw);
    return port * dw;
  endfunction

endpackage

// File: rtl/regbank_ip_ctr.sv
// Instruction-pointer register with Jump > Stall > increment priority.
// The increment wraps silently at DataWidth bits.
module regbank_ip_ctr #(
  parameter int                   DataWidth   = 16,
  parameter int                   IpStep      = 2,
  parameter logic [DataWidth-1:0] ResetVector = '0
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Jump,
  input  logic [DataWidth-1:0] JumpTarget,
  input  logic                 Stall,
  output logic [DataWidth-1:0] ip
);

  localparam logic [DataWidth-1:0] Step = DataWidth'(IpStep);

  // Stage p1: IP register
  always_ff @(posedge Clock) begin
    if (Reset)      ip <= ResetVector;
    else if (Jump)  ip <= JumpTarget;
    else if (!Stall) ip <= ip + Step;
  end

endmodule

// File: rtl/regbank_mp.sv
// Multi-port register bank: prioritized writes, same-cycle write-to-read
// forwarding, registered reads and an embedded instruction pointer.
module regbank_mp
  import regbank_pkg::*;
#(
  parameter int                   DataWidth     = DEF_DATA_WIDTH,
  parameter int                   NumRegs       = DEF_NUM_REGS,
  parameter int                   NumReadPorts  = 2,
  parameter int                   NumWritePorts = 2,
  parameter int                   IpStep        = DEF_IP_STEP,
  parameter logic [DataWidth-1:0] ResetVector   = '0,
  parameter int                   ZeroReg       = 1,
  localparam int                  AW            = $clog2(NumRegs)
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic [NumReadPorts*AW-1:0]        ReadAddr,
  output logic [NumReadPorts*DataWidth-1:0] ReadData,
  input  logic [NumWritePorts-1:0]          WriteEnable,
  input  logic [NumWritePorts*AW-1:0]       WriteAddr,
  input  logic [NumWritePorts*DataWidth-1:0] WriteData,
  input  logic                              Jump,
  input  logic [DataWidth-1:0]              JumpTarget,
  input  logic                              Stall,
  output logic [DataWidth-1:0]              IpOut,
  output logic                              WriteConflict
);

  localparam int            IpIdx  = ip_index(NumRegs);
  localparam logic [AW-1:0] IpAddr = AW'(IpIdx);

  logic [DataWidth-1:0] ip;
  logic [DataWidth-1:0] regs    [NumRegs];
  logic [DataWidth-1:0] wr_data [NumRegs];
  logic [NumRegs-1:0]   wr_hit;
  logic [NumRegs-1:0]   wr_dup;

  regbank_ip_ctr #(
    .DataWidth   (DataWidth),
    .IpStep      (IpStep),
    .ResetVector (ResetVector)
  ) u_ip_ctr (
    .Clock      (Clock),
    .Reset      (Reset),
    .Jump       (Jump),
    .JumpTarget (JumpTarget),
    .Stall      (Stall),
    .ip         (ip)
  );

  assign IpOut = ip;

  // Stage p0: per-register write arbitration; later ports override earlier ones
  for (genvar r = 0; r < NumRegs; r++) begin : g_arb
    localparam bit Writable = (r != IpIdx) && !((ZeroReg != 0) && (r == 0));
    logic                 hit;
    logic                 dup;
    logic [DataWidth-1:0] data;

    always_comb begin
      hit  = 1'b0;
      dup  = 1'b0;
      data = '0;
      if (Writable) begin
        for (int w = 0; w < NumWritePorts; w++) begin
          if (WriteEnable[w] &&
              (WriteAddr[addr_lsb(w, AW) +: AW] == AW'(r))) begin
            dup  = dup | hit;
            hit  = 1'b1;
            data = WriteData[data_lsb(w, DataWidth) +: DataWidth];
          end
        end
      end
    end

    assign wr_hit[r]  = hit;
    assign wr_dup[r]  = dup;
    assign wr_data[r] = data;
  end

  // Stage p1: register storage and conflict flag
  always_ff @(posedge Clock) begin
    for (int r = 0; r < NumRegs; r++) begin
      if (Reset)          regs[r] <= '0;
      else if (wr_hit[r]) regs[r] <= wr_data[r];
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) WriteConflict <= 1'b0;
    else       WriteConflict <= |wr_dup;
  end

  // Stage p1: registered read ports with IP, zero-register and forwarding bypass
  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    logic [AW-1:0]        raddr_p0;
    logic [DataWidth-1:0] rdata_p1;

    assign raddr_p0 = ReadAddr[addr_lsb(p, AW) +: AW];

    always_ff @(posedge Clock) begin
      if (Reset)                                rdata_p1 <= '0;
      else if (raddr_p0 == IpAddr)              rdata_p1 <= ip;
      else if ((ZeroReg != 0) && (raddr_p0 == '0)) rdata_p1 <= '0;
      else if (wr_hit[raddr_p0])                rdata_p1 <= wr_data[raddr_p0];
      else                                      rdata_p1 <= regs[raddr_p0];
    end

    assign ReadData[data_lsb(p, DataWidth) +: DataWidth] = rdata_p1;
  end

endmodule

// File: tb/tb_regbank_mp.sv
// Directed scoreboard bench for regbank_mp with default parameters.
// Stimulus pushes expected post-edge values; a monitor pops and compares.
module tb_regbank_mp;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  ReadAddr = '0;
  logic [31:0] ReadData;
  logic [1:0]  WriteEnable = '0;
  logic [7:0]  WriteAddr = '0;
  logic [31:0] WriteData = '0;
  logic        Jump = 1'b0;
  logic [15:0] JumpTarget = '0;
  logic        Stall = 1'b0;
  logic [15:0] IpOut;
  logic        WriteConflict;

  typedef struct {
    logic [15:0] rd0;
    logic [15:0] rd1;
    logic [15:0] ip;
    logic        cf;
    logic [3:0]  chk;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  regbank_mp dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .ReadAddr      (ReadAddr),
    .ReadData      (ReadData),
    .WriteEnable   (WriteEnable),
    .WriteAddr     (WriteAddr),
    .WriteData     (WriteData),
    .Jump          (Jump),
    .JumpTarget    (JumpTarget),
    .Stall         (Stall),
    .IpOut         (IpOut),
    .WriteConflict (WriteConflict)
  );

  always #5 Clock = ~Clock;

  task automatic cmp(input string name, input int id, input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s step %0d: got 0x%04h expected 0x%04h", name, id, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge, sampled 1 time unit after it
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk[0]) cmp("rd0", e.id, ReadData[15:0], e.rd0);
        if (e.chk[1]) cmp("rd1", e.id, ReadData[31:16], e.rd1);
        if (e.chk[2]) cmp("ip",  e.id, IpOut, e.ip);
        if (e.chk[3]) cmp("conflict", e.id, {15'd0, WriteConflict}, {15'd0, e.cf});
      end
    end
  end

  int step_id = 0;

  task automatic step(input logic rst, input logic [1:0] we,
                      input logic [3:0] wa0, input logic [15:0] wd0,
                      input logic [3:0] wa1, input logic [15:0] wd1,
                      input logic [3:0] ra0, input logic [3:0] ra1,
                      input logic jmp, input logic [15:0] jt, input logic stl,
                      input logic [15:0] e_rd0, input logic [15:0] e_rd1,
                      input logic [15:0] e_ip, input logic e_cf,
                      input logic [3:0] chk);
    exp_t e;
    @(negedge Clock);
    Reset       = rst;
    WriteEnable = we;
    WriteAddr   = {wa1, wa0};
    WriteData   = {wd1, wd0};
    ReadAddr    = {ra1, ra0};
    Jump        = jmp;
    JumpTarget  = jt;
    Stall       = stl;
    step_id++;
    e.rd0 = e_rd0; e.rd1 = e_rd1; e.ip = e_ip; e.cf = e_cf; e.chk = chk; e.id = step_id;
    sb.push_back(e);
  endtask

  initial begin
    // rst we  wa0 wd0      wa1 wd1      ra0 ra1 jmp jt       stl  rd0      rd1      ip       cf
    step(1, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0004, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0006, 0, 4'hF);
    // forwarding of R3 and later stored read
    step(0, 2'b01, 3, 16'h1234, 0, 16'h0000, 0,  3,  0, 16'h0000, 0, 16'h0000, 16'h1234, 16'h0008, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 3,  0,  0, 16'h0000, 0, 16'h1234, 16'h0000, 16'h000A, 0, 4'hF);
    // two ports hit R5: port 1 wins, conflict for one cycle
    step(0, 2'b11, 5, 16'hAAAA, 5, 16'h5555, 5,  3,  0, 16'h0000, 0, 16'h5555, 16'h1234, 16'h000C, 1, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 5, 15,  0, 16'h0000, 0, 16'h5555, 16'h000C, 16'h000E, 0, 4'hF);
    // stall twice at 0x0010, then jump overrides stall
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0010, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0,  0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0010, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 15, 0,  0, 16'h0000, 1, 16'h0010, 16'h0000, 16'h0010, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0,  1, 16'h0100, 1, 16'h0000, 16'h0000, 16'h0100, 0, 4'hF);
    // wrap from 0xFFFE and ignored write to the IP slot
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  0,  1, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'hFFFE, 0, 4'hF);
    step(0, 2'b01, 15, 16'h7777, 0, 16'h0000, 15, 0, 0, 16'h0000, 0, 16'hFFFE, 16'h0000, 16'h0000, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 15, 0,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002, 0, 4'hF);
    // zero register ignores writes and is not forwarded; R6 written alongside
    step(0, 2'b11, 0, 16'hBEEF, 6, 16'h6666, 0,  0,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0004, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0,  6,  0, 16'h0000, 0, 16'h0000, 16'h6666, 16'h0006, 0, 4'hF);
    // reset during jump and write
    step(1, 2'b01, 7, 16'h1111, 0, 16'h0000, 6,  5,  1, 16'h0200, 0, 16'h0000, 16'h0000, 16'h0000, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 6,  3,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 5,  7,  0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0004, 0, 4'hF);
    step(0, 2'b00, 0, 16'h0000, 0, 16'h0000, 15, 0,  0, 16'h0000, 0, 16'h0004, 16'h0000, 16'h0006, 0, 4'hF);

    @(negedge Clock);
    WriteEnable = '0;
    Jump        = 1'b0;
    Stall       = 1'b0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clock);
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regbank_mp.md
Name: regbank_mp

Overview:
- Parametrised multi-port register bank with an integrated instruction-pointer (IP) register, stall/jump control, write priority and same-cycle write-to-read forwarding.
- Sits between decode (read addresses), writeback (write ports) and fetch (IP output) in the core datapath.
- Generalises the single-write, two-read, fixed 16x16 bank to configurable width, depth and port counts.

Parameters:
- DataWidth, 16, register and IP width in bits.
- NumRegs, 16, architectural register count (power of two, >=4); the IP lives at index NumRegs-1.
- NumReadPorts, 2, number of registered read ports.
- NumWritePorts, 2, number of write ports.
- IpStep, 2, IP increment per non-stalled cycle.
- ResetVector, 0, IP value after reset.
- ZeroReg, 1, if 1 then register 0 reads as 0 and ignores writes.

Ports:
- Clock  in  1  clock
- Reset  in  1  synchronous reset
- ReadAddr  in  NumReadPorts*AW  packed read addresses; AW=$clog2(NumRegs); port p at bits [p*AW +: AW]
- ReadData  out  NumReadPorts*DataWidth  registered read data; packed the same way as ReadAddr
- WriteEnable  in  NumWritePorts  per-port write enable
- WriteAddr  in  NumWritePorts*AW  packed write addresses
- WriteData  in  NumWritePorts*DataWidth  packed write data
- Jump  in  1  load JumpTarget into the IP
- JumpTarget  in  DataWidth  jump destination
- Stall  in  1  hold the IP
- IpOut  out  DataWidth  current IP (direct register output)
- WriteConflict  out  1  registered flag: two or more enabled write ports targeted the same general register in the previous cycle

Behaviour:
- Reset (Reset, synchronous, active-high; clock Clock):
  - All general registers are set to 0.
  - ReadData is set to 0.
  - WriteConflict is set to 0.
  - The IP is set to ResetVector, so IpOut = ResetVector in the cycle after Reset is sampled.
  - Reset overrides Jump, Stall and all writes in the same cycle. Reset mid-operation discards any in-flight update.
- IP update, per cycle, in priority order:
  - Jump: ip <= JumpTarget. Jump wins over Stall.
  - else Stall: ip holds.
  - else ip <= ip + IpStep, truncated to DataWidth. The wrap from all-ones is silent.
- General writes:
  - A port writes at the clock edge when WriteEnable[w]=1.
  - A write to address NumRegs-1 (the IP) is ignored. The IP changes only via Jump or increment.
  - With ZeroReg=1, a write to address 0 is ignored.
  - When several enabled ports share an address, the highest-indexed port wins. WriteConflict is set to 1 the next cycle, and is otherwise 0 the next cycle.
- Reads (latency 1 cycle): ReadData[p] is registered each cycle with:
  - Address NumRegs-1: the current ip (the value before this edge's update).
  - Address 0 with ZeroReg=1: 0.
  - Otherwise, if an enabled write port targets the same address this cycle: the winning write's WriteData (forwarding).
  - Otherwise: the stored register value.
- Reads are not gated by Stall; ReadData updates every cycle.
- No combinational path from any input to IpOut or WriteConflict.

Decomposition:
- Package regbank_pkg holds:
  - the defaults for DataWidth, NumRegs and IpStep;
  - the function ip_index(NumRegs);
  - the packed-slice helper functions for addresses and data.
- Sub-module regbank_ip_ctr implements the IP register with Jump/Stall/increment priority. It is parametrised by DataWidth, IpStep and ResetVector.
- The write-arbitration and forwarding logic stays in regbank_mp as a generate loop.

Test Plan:
- Reset, then 3 idle cycles -> IpOut = 0, 2, 4, 6; ReadData all 0; WriteConflict = 0.
- Write port 0 writes R3=0x1234 while read port 1 reads R3 in the same cycle -> ReadData[1] = 0x1234 the next cycle (forwarded); a later read of R3 also returns 0x1234.
- Ports 0 and 1 both write R5, with 0xAAAA and 0x5555 -> R5 = 0x5555, WriteConflict = 1 for exactly one cycle.
- With IP = 0x0010, Stall=1 for 2 cycles, then Jump=1, Stall=1, JumpTarget=0x0100 -> IpOut = 0x0010, 0x0010, then 0x0100.
- IP = 0xFFFE with no stall -> IpOut = 0x0000 the next cycle. A write of 0x7777 to R15 is ignored: IpOut keeps incrementing and a read of R15 returns the pre-edge IP.
- With ZeroReg=1, write 0xBEEF to R0 and read R0 in the same cycle -> ReadData = 0. Assert Reset during a Jump -> IpOut = ResetVector and all registers are 0.
